// File: rtl/multicycle_control.sv
// Sequencing FSM for the multicycle RV32I core: one control step per cycle,
// memory ready handshake with optional timeout trap, retired-instruction counter.
module multicycle_control #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pcwrite,
   output logic             pcwritecond,
   output logic             pcsource,
   output logic             iord,
   output logic             memread,
   output logic             memwrite,
   output logic             irwrite,
   output logic             memtoreg,
   output logic             regwrite,
   output logic [1:0]       alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic [3:0]       state,
   output logic             halted,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_IEXEC  = 4'd9,
      S_IWB    = 4'd10,
      S_TRAP   = 4'd15
   } state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              halted_q, halted_d;
   logic [1:0]        cause_q, cause_d;

   logic       pcwrite_s, pcwritecond_s, pcsource_s, iord_s, memread_s, memwrite_s;
   logic       irwrite_s, memtoreg_s, regwrite_s;
   logic [1:0] alusrca_s, alusrcb_s, aluop_s;
   logic       retire_s, mem_state_s, timeout_s;

   // The PC-write gating with the zero flag happens in the datapath.
   logic       zero_unused_s;
   assign zero_unused_s = zero;

   assign timeout_s = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

   // Next-state, strobe decode, wait counter and retire bookkeeping
   always_comb begin
      state_d       = state_q;
      cause_d       = cause_q;
      pcwrite_s     = 1'b0;
      pcwritecond_s = 1'b0;
      pcsource_s    = 1'b0;
      iord_s        = 1'b0;
      memread_s     = 1'b0;
      memwrite_s    = 1'b0;
      irwrite_s     = 1'b0;
      memtoreg_s    = 1'b0;
      regwrite_s    = 1'b0;
      alusrca_s     = 2'd0;
      alusrcb_s     = 2'd0;
      aluop_s       = 2'd0;
      retire_s      = 1'b0;
      mem_state_s   = 1'b0;
      case (state_q)
         S_FETCH: begin
            memread_s   = 1'b1;
            mem_state_s = 1'b1;
            if (mem_ready) begin
               irwrite_s = 1'b1;
               pcwrite_s = 1'b1;
               alusrcb_s = 2'd1;
               state_d   = S_DECODE;
            end else if (timeout_s) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            alusrca_s = 2'd2;
            alusrcb_s = 2'd2;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC;
               OP_ADDI:      state_d = S_IEXEC;
               OP_BEQ:       state_d = S_BRANCH;
               default: begin
                  state_d = S_TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca_s = 2'd1;
            alusrcb_s = 2'd2;
            if (opcode == OP_SW) begin
               state_d = S_MEMWR;
            end else begin
               state_d = S_MEMRD;
            end
         end
         S_MEMRD: begin
            memread_s   = 1'b1;
            iord_s      = 1'b1;
            mem_state_s = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end else if (timeout_s) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               state_d = S_MEMRD;
            end
         end
         S_MEMWB: begin
            regwrite_s = 1'b1;
            memtoreg_s = 1'b1;
            retire_s   = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            memwrite_s  = 1'b1;
            iord_s      = 1'b1;
            mem_state_s = 1'b1;
            if (mem_ready) begin
               retire_s = 1'b1;
               state_d  = S_FETCH;
            end else if (timeout_s) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               state_d = S_MEMWR;
            end
         end
         S_EXEC: begin
            alusrca_s = 2'd1;
            alusrcb_s = 2'd0;
            aluop_s   = 2'd2;
            state_d   = S_RWB;
         end
         S_RWB, S_IWB: begin
            regwrite_s = 1'b1;
            retire_s   = 1'b1;
            state_d    = S_FETCH;
         end
         S_IEXEC: begin
            alusrca_s = 2'd1;
            alusrcb_s = 2'd2;
            state_d   = S_IWB;
         end
         S_BRANCH: begin
            alusrca_s     = 2'd1;
            alusrcb_s     = 2'd0;
            aluop_s       = 2'd1;
            pcwritecond_s = 1'b1;
            pcsource_s    = 1'b1;
            retire_s      = 1'b1;
            state_d       = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
         end
      endcase

      if (state_d != state_q) begin
         wait_d = {WAIT_W{1'b0}};
      end else if (mem_state_s && !mem_ready) begin
         wait_d = wait_q + WAIT_W'(1);
      end else begin
         wait_d = wait_q;
      end

      if (retire_s) begin
         instret_d = instret_q + CNT_W'(1);
      end else begin
         instret_d = instret_q;
      end

      halted_d = halted_q | (state_d == S_TRAP);
   end

   // State, wait counter, retire counter and trap status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         wait_q    <= {WAIT_W{1'b0}};
         instret_q <= {CNT_W{1'b0}};
         halted_q  <= 1'b0;
         cause_q   <= 2'd0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         instret_q <= instret_d;
         halted_q  <= halted_d;
         cause_q   <= cause_d;
      end
   end

   // Every output is held low for as long as reset is asserted.
   assign pcwrite     = rst & pcwrite_s;
   assign pcwritecond = rst & pcwritecond_s;
   assign pcsource    = rst & pcsource_s;
   assign iord        = rst & iord_s;
   assign memread     = rst & memread_s;
   assign memwrite    = rst & memwrite_s;
   assign irwrite     = rst & irwrite_s;
   assign memtoreg    = rst & memtoreg_s;
   assign regwrite    = rst & regwrite_s;
   assign alusrca     = rst ? alusrca_s : 2'd0;
   assign alusrcb     = rst ? alusrcb_s : 2'd0;
   assign aluop       = rst ? aluop_s : 2'd0;
   assign state       = rst ? state_q : 4'd0;
   assign halted      = rst & halted_q;
   assign trap_cause  = rst ? cause_q : 2'd0;
   assign instret     = rst ? instret_q : {CNT_W{1'b0}};

endmodule
